// File: rtl/hex_display.sv
// Seven-segment display controller: captures a value through a load/ready
// handshake and shows it as raw hex or as unsigned decimal.
// Decimal conversion uses a sequential double-dabble engine.
// Segment outputs are active-low: bits [6:0] = g..a, bit 7 = dp.
//
// Handshake: a request is taken on a rising edge where load && ready.
// ready is registered and is high only in IDLE. A load while busy is dropped.
module hex_display #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  dec,
    input  logic                  lzb,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  load,
    output logic                  ready,
    output logic [8*DIGITS-1:0]   hex,
    output logic [1:0]            fsm_state
);
    localparam int W    = 4 * DIGITS;
    localparam int CW   = $clog2(W + 1);
    localparam int BW   = $clog2(BLINK_DIV);
    // Display settings packed as {ovf, lzb, dp, en, blink}.
    localparam int CFGW = 2 + 3 * DIGITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // 10^DIGITS always fits in W bits because 10^D < 16^D.
    function automatic logic [W-1:0] pow10(input int n);
        logic [W-1:0] r;
        r = W'(1);
        for (int i = 0; i < n; i++) r = r * W'(10);
        return r;
    endfunction

    localparam logic [W-1:0] DEC_LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Turns digit nibbles plus display settings into the full segment word.
    function automatic logic [8*DIGITS-1:0] render(input logic [W-1:0] dig,
                                                   input logic [CFGW-1:0] cfg,
                                                   input logic ph);
        logic [8*DIGITS-1:0] r;
        logic                lead;
        logic                blank;
        logic [6:0]          seg;
        logic                ovf;
        logic                z;
        logic [DIGITS-1:0]   p;
        logic [DIGITS-1:0]   e;
        logic [DIGITS-1:0]   b;
        ovf  = cfg[CFGW-1];
        z    = cfg[CFGW-2];
        p    = cfg[3*DIGITS-1:2*DIGITS];
        e    = cfg[2*DIGITS-1:DIGITS];
        b    = cfg[DIGITS-1:0];
        r    = '1;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead  = lead && (dig[4*i +: 4] == 4'd0);
            seg   = ovf ? 7'h3F : seg_glyph(dig[4*i +: 4]);
            blank = !e[i] || (b[i] && ph) || (z && !ovf && lead && (i != 0));
            r[8*i +: 8] = blank ? 8'hFF : {~p[i], seg};
        end
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      sh_q, sh_d;
    logic [W-1:0]      bcd_q, bcd_d;
    logic [W-1:0]      adj;
    logic [CFGW-1:0]   pend_cfg_q, pend_cfg_d;
    logic [W-1:0]      act_dig_q, act_dig_d;
    logic [CFGW-1:0]   act_cfg_q, act_cfg_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic [8*DIGITS-1:0] hex_q, hex_d;
    logic              accept;

    assign accept = load && ready_q;

    // FSM, capture and double-dabble datapath next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        pend_cfg_d = pend_cfg_q;
        act_dig_d  = act_dig_q;
        act_cfg_d  = act_cfg_q;
        adj        = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec) begin
                        state_d    = S_CONV;
                        cnt_d      = CW'(W);
                        sh_d       = value;
                        bcd_d      = '0;
                        pend_cfg_d = {(value >= DEC_LIMIT), lzb, dp, digit_en, blink_mask};
                    end else begin
                        act_dig_d  = value;
                        act_cfg_d  = {1'b0, lzb, dp, digit_en, blink_mask};
                    end
                end
            end
            S_CONV: begin
                bcd_d = {adj[W-2:0], sh_q[W-1]};
                sh_d  = {sh_q[W-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                act_dig_d = bcd_q;
                act_cfg_d = pend_cfg_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // Free-running blink timebase; the phase flips on every wrap.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // In COMMIT the finished BCD result goes straight to the output so the
    // glyphs land on the same edge the FSM returns to IDLE.
    always_comb begin
        if (state_q == S_COMMIT) hex_d = render(bcd_q, pend_cfg_q, phase_q);
        else                     hex_d = render(act_dig_q, act_cfg_q, phase_q);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            cnt_q       <= '0;
            sh_q        <= '0;
            bcd_q       <= '0;
            pend_cfg_q  <= '0;
            act_dig_q   <= '0;
            act_cfg_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            hex_q       <= '1;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            bcd_q       <= bcd_d;
            pend_cfg_q  <= pend_cfg_d;
            act_dig_q   <= act_dig_d;
            act_cfg_q   <= act_cfg_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hex_q       <= hex_d;
        end
    end

    assign ready     = ready_q;
    assign hex       = hex_q;
    assign fsm_state = state_q;
endmodule
